// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial selection, per-mode order/tap lookup and FSM state encoding.
package prbs_pkg;

   localparam int STATE_W = 31;

   typedef enum logic [1:0] {
      MODE_PRBS7  = 2'd0,
      MODE_PRBS15 = 2'd1,
      MODE_PRBS23 = 2'd2,
      MODE_PRBS31 = 2'd3
   } prbs_mode_e;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } chk_state_e;

   function automatic int prbs_order(input logic [1:0] mode);
      case (mode)
         2'd0:    return 7;
         2'd1:    return 15;
         2'd2:    return 23;
         default: return 31;
      endcase
   endfunction

   // Bit index of the x^N term inside the newest-at-bit-0 state.
   function automatic logic [4:0] prbs_msb(input logic [1:0] mode);
      return 5'(prbs_order(mode) - 1);
   endfunction

   function automatic logic [4:0] prbs_tap(input logic [1:0] mode);
      case (mode)
         2'd0:    return 5'd5;
         2'd1:    return 5'd13;
         2'd2:    return 5'd17;
         default: return 5'd27;
      endcase
   endfunction

   // Last value of the seed beat counter: ceil(order/width) - 1.
   function automatic logic [5:0] seed_last_beat(input logic [1:0] mode, input int width);
      return 6'((prbs_order(mode) + width - 1) / width - 1);
   endfunction

endpackage

// File: rtl/prbs_par_step.sv
// Combinational multi-step PRBS generator: advances the LFSR WIDTH steps and returns the
// generated bits, earliest at bit 0.
module prbs_par_step import prbs_pkg::*; #(
   parameter int WIDTH = 1
) (
   input  logic [STATE_W-1:0] state,
   input  logic [1:0]         mode,
   output logic [WIDTH-1:0]   exp_bits,
   output logic [STATE_W-1:0] next_state
);

   logic [4:0] msb_idx;
   logic [4:0] tap_idx;

   assign msb_idx = prbs_msb(mode);
   assign tap_idx = prbs_tap(mode);

   always_comb begin
      logic [STATE_W-1:0] s;
      logic               fb;
      s        = state;
      fb       = 1'b0;
      exp_bits = '0;
      for (int i = 0; i < WIDTH; i++) begin
         fb          = s[msb_idx] ^ s[tap_idx];
         exp_bits[i] = fb;
         s           = {s[STATE_W-2:0], fb};
      end
      next_state = s;
   end

endmodule

// File: rtl/prbs_multi_checker.sv
// Multi-polynomial PRBS checker: self-seeds from received data, tracks lock, and keeps
// saturating bit / error / lock-loss counters for BER measurement.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SEED   | shifting received bits into history until LFSR can be loaded
//   ST_VERIFY | LFSR predicting data; counting consecutive clean beats
//   ST_LOCKED | LFSR free-running; counters and loss-of-lock window active
module prbs_multi_checker import prbs_pkg::*; #(
   parameter int WIDTH       = 1,
   parameter int CNT_W       = 32,
   parameter int LOCK_GOOD   = 16,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [1:0]       mode,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_in_valid,
   output logic             locked,
   output logic [CNT_W-1:0] total_bits,
   output logic [CNT_W-1:0] total_bit_errors,
   output logic [7:0]       lock_loss_count
);

   localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
   localparam int WIN_W  = $clog2(WINDOW + 1);
   localparam int WERR_W = $clog2(LOSS_THRESH + WIDTH + 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0] LOSS_LIM  = WERR_W'(LOSS_THRESH);

   chk_state_e         state;
   logic [1:0]         mode_q;
   logic [STATE_W-1:0] hist;
   logic [STATE_W-1:0] hist_next;
   logic [STATE_W-1:0] lfsr;
   logic [STATE_W-1:0] step_state;
   logic [WIDTH-1:0]   exp_bits;
   logic [5:0]         seed_cnt;
   logic [5:0]         seed_last;
   logic [GOOD_W-1:0]  good_cnt;
   logic [WIN_W-1:0]   win_beats;
   logic [WERR_W-1:0]  win_errs;
   logic [WERR_W-1:0]  win_err_sum;
   logic [3:0]         beat_errs;
   logic [CNT_W:0]     bits_sum;
   logic [CNT_W:0]     errs_sum;
   logic               mode_chg;
   logic               beat;
   logic               win_loss;

   prbs_par_step #(.WIDTH(WIDTH)) u_step (
      .state      (lfsr),
      .mode       (mode_q),
      .exp_bits   (exp_bits),
      .next_state (step_state)
   );

   always_comb begin
      hist_next = hist;
      for (int i = 0; i < WIDTH; i++) begin
         hist_next = {hist_next[STATE_W-2:0], data_in[i]};
      end
   end

   always_comb begin
      beat_errs = '0;
      for (int i = 0; i < WIDTH; i++) begin
         beat_errs = beat_errs + 4'(data_in[i] ^ exp_bits[i]);
      end
   end

   assign seed_last   = seed_last_beat(mode_q, WIDTH);
   assign mode_chg    = (mode != mode_q);
   assign beat        = data_in_valid && !mode_chg;
   assign win_err_sum = win_errs + WERR_W'(beat_errs);
   assign win_loss    = (win_err_sum >= LOSS_LIM);
   assign bits_sum    = {1'b0, total_bits} + (CNT_W+1)'(WIDTH);
   assign errs_sum    = {1'b0, total_bit_errors} + (CNT_W+1)'(beat_errs);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state            <= ST_SEED;
         locked           <= 1'b0;
         mode_q           <= mode;
         hist             <= '0;
         lfsr             <= '0;
         seed_cnt         <= '0;
         good_cnt         <= '0;
         win_beats        <= '0;
         win_errs         <= '0;
         total_bits       <= '0;
         total_bit_errors <= '0;
         lock_loss_count  <= '0;
      end else begin
         // A polynomial change discards the current beat and restarts acquisition.
         if (mode_chg) begin
            mode_q    <= mode;
            state     <= ST_SEED;
            locked    <= 1'b0;
            seed_cnt  <= '0;
            good_cnt  <= '0;
            win_beats <= '0;
            win_errs  <= '0;
         end else if (data_in_valid) begin
            unique case (state)
               ST_SEED: begin
                  hist <= hist_next;
                  if (seed_cnt == seed_last) begin
                     lfsr     <= hist_next;
                     seed_cnt <= '0;
                     good_cnt <= '0;
                     state    <= ST_VERIFY;
                  end else begin
                     seed_cnt <= seed_cnt + 6'd1;
                  end
               end
               ST_VERIFY: begin
                  lfsr <= step_state;
                  if (beat_errs != '0) begin
                     state    <= ST_SEED;
                     seed_cnt <= '0;
                  end else if (good_cnt == GOOD_LAST) begin
                     state     <= ST_LOCKED;
                     locked    <= 1'b1;
                     win_beats <= '0;
                     win_errs  <= '0;
                  end else begin
                     good_cnt <= good_cnt + 1'b1;
                  end
               end
               ST_LOCKED: begin
                  lfsr <= step_state;
                  if (win_loss) begin
                     state     <= ST_SEED;
                     locked    <= 1'b0;
                     seed_cnt  <= '0;
                     win_beats <= '0;
                     win_errs  <= '0;
                  end else if (win_beats == WIN_LAST) begin
                     win_beats <= '0;
                     win_errs  <= '0;
                  end else begin
                     win_beats <= win_beats + 1'b1;
                     win_errs  <= win_err_sum;
                  end
               end
               default: begin
                  state  <= ST_SEED;
                  locked <= 1'b0;
               end
            endcase
         end

         if (clear) begin
            total_bits       <= '0;
            total_bit_errors <= '0;
            lock_loss_count  <= '0;
         end else if (beat && state == ST_LOCKED) begin
            total_bits       <= bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
            total_bit_errors <= errs_sum[CNT_W] ? '1 : errs_sum[CNT_W-1:0];
            if (win_loss && lock_loss_count != 8'hFF) begin
               lock_loss_count <= lock_loss_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_prbs_multi_checker.sv
// Scoreboard bench for prbs_multi_checker: a WIDTH=1/CNT_W=32 instance and a WIDTH=4/CNT_W=8
// instance, driven in turn from a bit-sequence reference model.
module tb_prbs_multi_checker;

   localparam int LOCK_GOOD   = 16;
   localparam int WINDOW      = 64;
   localparam int LOSS_THRESH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] mode = 2'd3;
   logic [0:0] data_a = '0;
   logic       valid_a = 1'b0;
   logic [3:0] data_b = '0;
   logic       valid_b = 1'b0;

   logic        locked_a, locked_b;
   logic [31:0] tb_a, te_a;
   logic [7:0]  tb_b, te_b, lc_a, lc_b;

   prbs_multi_checker #(.WIDTH(1), .CNT_W(32)) dut_a (
      .clk(clk), .rstn(rstn), .mode(mode), .clear(clear),
      .data_in(data_a), .data_in_valid(valid_a),
      .locked(locked_a), .total_bits(tb_a), .total_bit_errors(te_a), .lock_loss_count(lc_a)
   );

   prbs_multi_checker #(.WIDTH(4), .CNT_W(8)) dut_b (
      .clk(clk), .rstn(rstn), .mode(mode), .clear(clear),
      .data_in(data_b), .data_in_valid(valid_b),
      .locked(locked_b), .total_bits(tb_b), .total_bit_errors(te_b), .lock_loss_count(lc_b)
   );

   typedef struct {
      bit     s;
      bit     lk;
      longint tbits;
      longint terrs;
      int     lc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model state
   bit         sel;
   int         W;
   longint     cmax;
   int         m_phase;  // 0 seeding, 1 verifying, 2 locked
   bit         recv[$];
   bit         pred[$];
   int         seed_n, good, wb, we;
   bit [1:0]   m_mode;
   longint     m_tb, m_te;
   int         m_lc;
   bit         m_lk;

   // transmitter
   bit         tx[$];
   bit [1:0]   tx_mode;

   function automatic int ord(input bit [1:0] m);
      case (m)
         2'd0:    return 7;
         2'd1:    return 15;
         2'd2:    return 23;
         default: return 31;
      endcase
   endfunction

   function automatic int tapn(input bit [1:0] m);
      case (m)
         2'd0:    return 6;
         2'd1:    return 14;
         2'd2:    return 18;
         default: return 28;
      endcase
   endfunction

   task automatic model_step(input bit rst, input bit [1:0] md, input bit clr,
                             input bit vld, input bit [3:0] d);
      int  n, t, errs;
      bit  e, inlock, loss;
      errs = 0; inlock = 0; loss = 0;
      if (rst) begin
         recv.delete(); pred.delete();
         for (int i = 0; i < 31; i++) begin recv.push_back(1'b0); pred.push_back(1'b0); end
         m_phase = 0; seed_n = 0; good = 0; wb = 0; we = 0; m_mode = md;
         m_tb = 0; m_te = 0; m_lc = 0; m_lk = 0;
         return;
      end
      if (md != m_mode) begin
         m_mode = md; m_phase = 0; seed_n = 0; good = 0; wb = 0; we = 0;
      end else if (vld) begin
         n = ord(m_mode); t = tapn(m_mode);
         if (m_phase == 0) begin
            for (int i = 0; i < W; i++) recv.push_back(d[i]);
            while (recv.size() > 40) void'(recv.pop_front());
            seed_n++;
            if (seed_n == (n + W - 1) / W) begin
               pred = recv; seed_n = 0; good = 0; m_phase = 1;
            end
         end else begin
            for (int i = 0; i < W; i++) begin
               e = pred[pred.size() - n] ^ pred[pred.size() - t];
               pred.push_back(e);
               if (e != d[i]) errs++;
            end
            while (pred.size() > 40) void'(pred.pop_front());
            if (m_phase == 1) begin
               if (errs != 0) begin m_phase = 0; seed_n = 0; end
               else begin
                  good++;
                  if (good == LOCK_GOOD) begin m_phase = 2; wb = 0; we = 0; end
               end
            end else begin
               inlock = 1;
               we += errs;
               if (we >= LOSS_THRESH) begin
                  loss = 1; m_phase = 0; seed_n = 0; wb = 0; we = 0;
               end else begin
                  wb++;
                  if (wb == WINDOW) begin wb = 0; we = 0; end
               end
            end
         end
      end
      if (clr) begin
         m_tb = 0; m_te = 0; m_lc = 0;
      end else if (inlock) begin
         m_tb = (m_tb + W > cmax) ? cmax : m_tb + W;
         m_te = (m_te + errs > cmax) ? cmax : m_te + errs;
         if (loss && m_lc < 255) m_lc++;
      end
      m_lk = (m_phase == 2);
   endtask

   task automatic tx_seed(input bit [1:0] md);
      tx.delete();
      for (int i = 0; i < 30; i++) tx.push_back(1'($urandom_range(0, 1)));
      tx.push_back(1'b1);
      tx_mode = md;
   endtask

   task automatic tx_beat(output bit [3:0] d);
      bit b;
      d = '0;
      for (int i = 0; i < W; i++) begin
         b = tx[tx.size() - ord(tx_mode)] ^ tx[tx.size() - tapn(tx_mode)];
         tx.push_back(b);
         d[i] = b;
      end
      while (tx.size() > 40) void'(tx.pop_front());
   endtask

   // Applies one cycle of inputs, records the model's expected outputs, returns #1 after the edge.
   task automatic drive(input bit rst, input bit clr, input bit vld, input bit [3:0] d);
      rstn  = !rst;
      clear = clr;
      if (sel) begin valid_b = vld; data_b = d; valid_a = 1'b0; end
      else begin valid_a = vld; data_a = d[0]; valid_b = 1'b0; end
      model_step(rst, mode, clr, vld, d);
      sb.push_back('{sel, m_lk, m_tb, m_te, m_lc});
      @(posedge clk);
      #1;
   endtask

   task automatic beats(input int n, input int err_pct, input int gap_pct, input int clr_pct);
      bit [3:0] d;
      int       k;
      k = 0;
      while (k < n) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            drive(0, 0, 0, 4'($urandom));
         end else begin
            tx_beat(d);
            if ($urandom_range(0, 99) < err_pct) d[$urandom_range(0, W - 1)] ^= 1'b1;
            drive(0, $urandom_range(0, 99) < clr_pct, 1, d);
            k++;
         end
      end
   endtask

   task automatic chk(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   initial begin : monitor
      forever begin
         int     n;
         exp_t   e;
         bit     a_lk;
         longint a_tb, a_te;
         int     a_lc;
         @(posedge clk);
         n = sb.size();
         @(negedge clk);
         if (n > 0) begin
            e    = sb.pop_front();
            a_lk = e.s ? locked_b : locked_a;
            a_tb = e.s ? longint'(tb_b) : longint'(tb_a);
            a_te = e.s ? longint'(te_b) : longint'(te_a);
            a_lc = e.s ? int'(lc_b) : int'(lc_a);
            n_cmp++;
            if (a_lk != e.lk || a_tb != e.tbits || a_te != e.terrs || a_lc != e.lc) begin
               n_bad++;
               $display("FAIL sb dut%0d t=%0t: locked %0d/%0d bits %0d/%0d errs %0d/%0d loss %0d/%0d (got/expected)",
                        e.s, $time, a_lk, e.lk, a_tb, e.tbits, a_te, e.terrs, a_lc, e.lc);
            end
         end
      end
   end

   initial begin : stim
      bit [3:0] d;

      // ---- WIDTH=1, CNT_W=32, PRBS31 ----
      sel = 0; W = 1; cmax = 64'hFFFF_FFFF; mode = 2'd3;
      tx_seed(2'd3);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      chk("reset_locked", locked_a, 0);
      chk("reset_bits", tb_a, 0);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 46; i++) begin tx_beat(d); drive(0, 0, 1, d); end
      chk("a_lock_before_47", locked_a, 0);
      tx_beat(d); drive(0, 0, 1, d);
      chk("a_lock_at_47", locked_a, 1);
      beats(1000, 0, 20, 0);
      chk("a_bits_1000", tb_a, 1000);
      chk("a_errs_0", te_a, 0);
      tx_beat(d); d ^= 4'b1; drive(0, 0, 1, d);
      chk("a_single_err", te_a, 1);
      chk("a_single_locked", locked_a, 1);
      chk("a_single_loss", lc_a, 0);
      beats(30, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin tx_beat(d); drive(0, 0, 1, d); end
         if (k == 7) chk("a_locked_after_7", locked_a, 1);
         tx_beat(d); d ^= 4'b1; drive(0, 0, 1, d);
      end
      chk("a_unlock_8th", locked_a, 0);
      chk("a_loss_count", lc_a, 1);
      for (int i = 0; i < 46; i++) begin tx_beat(d); drive(0, 0, 1, d); end
      chk("a_relock_before_47", locked_a, 0);
      tx_beat(d); drive(0, 0, 1, d);
      chk("a_relock_47", locked_a, 1);
      beats(400, 3, 20, 0);
      tx_beat(d); drive(0, 1, 1, d);
      chk("a_clear_bits", tb_a, 0);
      chk("a_clear_errs", te_a, 0);
      chk("a_clear_loss", lc_a, 0);
      beats(100, 0, 10, 0);
      drive(1, 0, 0, 0);
      chk("a_rst_locked", locked_a, 0);
      chk("a_rst_bits", tb_a, 0);
      chk("a_rst_errs", te_a, 0);
      chk("a_rst_loss", lc_a, 0);

      // ---- WIDTH=4, CNT_W=8, PRBS7 ----
      sel = 1; W = 4; cmax = 255; mode = 2'd0;
      tx_seed(2'd0);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      for (int i = 0; i < 17; i++) begin tx_beat(d); drive(0, 0, 1, d); end
      chk("b_lock_before_18", locked_b, 0);
      tx_beat(d); drive(0, 0, 1, d);
      chk("b_lock_at_18", locked_b, 1);
      beats(70, 0, 15, 0);
      chk("b_bits_sat", tb_b, 255);
      chk("b_errs_0", te_b, 0);
      tx_beat(d); drive(0, 1, 1, d);
      chk("b_clear_bits", tb_b, 0);
      chk("b_clear_errs", te_b, 0);
      mode = 2'd1;
      tx_beat(d); drive(0, 0, 1, d);
      chk("b_mode_unlock", locked_b, 0);
      tx_seed(2'd1);
      for (int i = 0; i < 20; i++) begin tx_beat(d); drive(0, 0, 1, d); end
      chk("b_relock_prbs15", locked_b, 1);
      for (int r = 0; r < 6; r++) begin
         mode = 2'($urandom_range(0, 3));
         tx_seed(mode);
         beats($urandom_range(30, 150), $urandom_range(0, 15), 25, 2);
      end
      beats(20, 100, 10, 0);

      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
